// File: rtl/round_robin_arbiter_with_lock_and_timeout_if.sv
// ============================================================================
// Module   : round_robin_arbiter_with_lock_and_timeout_if
// Brief    : Request/grant bundle between requesters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface round_robin_arbiter_with_lock_and_timeout_if #(
    parameter int N_REQ = 4
);
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] requests;
    logic [N_REQ-1:0] grants;
    logic             grant_valid;
    logic [IDXW-1:0]  grant_index;
    logic             timeout;

    modport master (
        output requests,
        input  grants,
        input  grant_valid,
        input  grant_index,
        input  timeout
    );

    modport slave (
        input  requests,
        output grants,
        output grant_valid,
        output grant_index,
        output timeout
    );
endinterface

`default_nettype wire

// File: rtl/round_robin_arbiter_with_lock_and_timeout.sv
// ============================================================================
// Module   : round_robin_arbiter_with_lock_and_timeout
// Brief    : Round-robin arbiter; owner keeps the grant up to MAX_HOLD cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_robin_arbiter_with_lock_and_timeout #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    round_robin_arbiter_with_lock_and_timeout_if.slave bus
);
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW   = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] c_MAX_HOLD = CW'(MAX_HOLD);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           r_state, w_nxt_state;
    logic [IDXW-1:0]  r_last, w_nxt_last;
    logic [CW-1:0]    r_cnt, w_nxt_cnt;
    logic [N_REQ-1:0] r_grants, w_nxt_grants;
    logic [IDXW-1:0]  r_index, w_nxt_index;
    logic             r_valid;
    logic             r_timeout, w_nxt_timeout;

    logic             w_pick_found;
    logic [IDXW-1:0]  w_pick_idx;
    logic [IDXW-1:0]  w_scan_idx;
    logic             w_owner_req;

    // Scan from the farthest candidate down to last+1 so the nearest set bit
    // overwrites the others; the current owner ends up with lowest priority.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_scan_idx = IDXW'((int'(r_last) + k) % N_REQ);
            if (bus.requests[w_scan_idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
        end
    end

    assign w_owner_req = bus.requests[r_last];

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_last    = r_last;
        w_nxt_cnt     = r_cnt;
        w_nxt_grants  = r_grants;
        w_nxt_index   = r_index;
        w_nxt_timeout = 1'b0;

        if (r_state == S_GRANT && w_owner_req && r_cnt < c_MAX_HOLD) begin
            w_nxt_cnt = r_cnt + CW'(1);
        end else if (w_pick_found) begin
            // New grant: fresh arbitration, release hand-off or forced rotation.
            w_nxt_timeout = (r_state == S_GRANT) && w_owner_req;
            w_nxt_state   = S_GRANT;
            w_nxt_last    = w_pick_idx;
            w_nxt_index   = w_pick_idx;
            w_nxt_cnt     = CW'(1);
            w_nxt_grants  = N_REQ'(1) << w_pick_idx;
        end else begin
            w_nxt_state  = S_IDLE;
            w_nxt_cnt    = '0;
            w_nxt_grants = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last    <= IDXW'(N_REQ - 1);
            r_cnt     <= '0;
            r_grants  <= '0;
            r_index   <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_last    <= w_nxt_last;
            r_cnt     <= w_nxt_cnt;
            r_grants  <= w_nxt_grants;
            r_index   <= w_nxt_index;
            r_valid   <= |w_nxt_grants;
            r_timeout <= w_nxt_timeout;
        end
    end

    assign bus.grants      = r_grants;
    assign bus.grant_valid = r_valid;
    assign bus.grant_index = r_index;
    assign bus.timeout     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_round_robin_arbiter_with_lock_and_timeout.sv
// ============================================================================
// Module   : tb_round_robin_arbiter_with_lock_and_timeout
// Brief    : Bench for the arbiter at MAX_HOLD=4 and MAX_HOLD=1 against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_round_robin_arbiter_with_lock_and_timeout;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    round_robin_arbiter_with_lock_and_timeout_if #(.N_REQ(N)) bus4 ();
    round_robin_arbiter_with_lock_and_timeout_if #(.N_REQ(N)) bus1 ();

    round_robin_arbiter_with_lock_and_timeout #(.N_REQ(N), .MAX_HOLD(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    round_robin_arbiter_with_lock_and_timeout #(.N_REQ(N), .MAX_HOLD(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: owner=-1 means nobody holds the resource.
    typedef struct {
        int owner;
        int held;
        int last;
        int index;
        bit to;
    } model_t;

    model_t m4, m1;

    function automatic model_t model_reset();
        model_t r;
        r.owner = -1;
        r.held  = 0;
        r.last  = N - 1;
        r.index = 0;
        r.to    = 1'b0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t m, input logic [N-1:0] req, input int max_hold);
        model_t r;
        int     win;
        r    = m;
        r.to = 1'b0;
        if (m.owner >= 0 && req[m.owner] && m.held < max_hold) begin
            r.held = m.held + 1;
            return r;
        end
        if (m.owner >= 0 && req[m.owner]) r.to = 1'b1;
        if (req == '0) begin
            r.owner = -1;
            r.held  = 0;
            return r;
        end
        win = -1;
        for (int k = 1; k <= N; k++) begin
            if (win < 0 && req[(m.last + k) % N]) win = (m.last + k) % N;
        end
        r.owner = win;
        r.last  = win;
        r.index = win;
        r.held  = 1;
        return r;
    endfunction

    function automatic logic [N-1:0] exp_grants(input model_t m);
        return (m.owner < 0) ? '0 : (N'(1) << m.owner);
    endfunction

    task automatic tick(input logic [N-1:0] req, input bit r);
        bus4.requests = req;
        bus1.requests = req;
        rst           = r;
        @(posedge clk);
        #1;
        if (r) begin
            m4 = model_reset();
            m1 = model_reset();
        end else begin
            m4 = model_step(m4, req, 4);
            m1 = model_step(m1, req, 1);
        end
    endtask

    task automatic test_reset();
        tick('0, 1'b1);
        tick('0, 1'b1);
        checks++;
        if ({bus4.grants, bus4.grant_valid, bus4.grant_index, bus4.timeout} !== 8'b0 ||
            {bus1.grants, bus1.grant_valid, bus1.grant_index, bus1.timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset: got g4=%b v=%b i=%0d t=%b g1=%b, expected all zero",
                     bus4.grants, bus4.grant_valid, bus4.grant_index, bus4.timeout, bus1.grants);
        end
    endtask

    task automatic test_rotation();
        for (int c = 0; c < 21; c++) begin
            tick(4'b1111, 1'b0);
            checks++;
            if (bus4.grants !== exp_grants(m4) || bus4.grant_valid !== (m4.owner >= 0) ||
                bus4.grant_index !== 2'(m4.index) || bus4.timeout !== m4.to) begin
                errors++;
                $display("FAIL rotation c%0d: got g=%b i=%0d t=%b expected g=%b i=%0d t=%b",
                         c, bus4.grants, bus4.grant_index, bus4.timeout, exp_grants(m4), m4.index, m4.to);
            end
            if (c == 0 || c == 4) begin
                checks++;
                if (bus4.grants !== (c == 0 ? 4'b0001 : 4'b0010)) begin
                    errors++;
                    $display("FAIL rotation_fixed c%0d: got %b", c, bus4.grants);
                end
            end
        end
        tick('0, 1'b0);
    endtask

    task automatic test_single_release();
        logic [N-1:0] req;
        for (int c = 0; c < 4; c++) begin
            req = (c < 2) ? 4'b0100 : 4'b0000;
            tick(req, 1'b0);
            checks++;
            if (bus4.grants !== exp_grants(m4) || bus4.grant_valid !== (m4.owner >= 0) ||
                bus4.timeout !== 1'b0) begin
                errors++;
                $display("FAIL single_release c%0d: got g=%b v=%b t=%b expected g=%b v=%b t=0",
                         c, bus4.grants, bus4.grant_valid, bus4.timeout, exp_grants(m4), m4.owner >= 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        tick('0, 1'b1);
        tick(4'b0010, 1'b0);
        tick(4'b0010, 1'b0);
        tick(4'b1001, 1'b0);
        checks++;
        if (bus4.grants !== 4'b1000 || bus4.grant_index !== 2'd3 || bus4.timeout !== 1'b0 ||
            bus4.grants !== exp_grants(m4)) begin
            errors++;
            $display("FAIL back_to_back: got g=%b i=%0d t=%b expected g=1000 i=3 t=0",
                     bus4.grants, bus4.grant_index, bus4.timeout);
        end
        tick('0, 1'b0);
    endtask

    task automatic test_sole_timeout();
        for (int c = 1; c <= 10; c++) begin
            tick(4'b0100, 1'b0);
            checks++;
            if (bus4.grants !== 4'b0100 || bus4.timeout !== m4.to ||
                bus4.timeout !== (c == 5 || c == 9)) begin
                errors++;
                $display("FAIL sole_timeout c%0d: got g=%b t=%b expected g=0100 t=%b",
                         c, bus4.grants, bus4.timeout, m4.to);
            end
        end
        tick('0, 1'b0);
    endtask

    task automatic test_reset_mid_grant();
        tick('0, 1'b1);
        for (int c = 0; c < 3; c++) tick(4'b0010, 1'b0);
        tick(4'b0010, 1'b1);
        checks++;
        if (bus4.grants !== 4'b0 || bus4.timeout !== 1'b0 || bus4.grant_valid !== 1'b0 ||
            bus4.grant_index !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: got g=%b v=%b i=%0d t=%b expected zeros",
                     bus4.grants, bus4.grant_valid, bus4.grant_index, bus4.timeout);
        end
        tick(4'b1111, 1'b0);
        checks++;
        if (bus4.grants !== 4'b0001 || bus1.grants !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: got g4=%b g1=%b expected 0001",
                     bus4.grants, bus1.grants);
        end
        tick('0, 1'b0);
    endtask

    task automatic test_max_hold1();
        tick('0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            tick(4'b0011, 1'b0);
            checks++;
            if (bus1.grants !== ((c % 2 == 0) ? 4'b0001 : 4'b0010) ||
                bus1.timeout !== (c > 0) || bus1.grant_valid !== (|bus1.grants) ||
                bus1.grants !== exp_grants(m1)) begin
                errors++;
                $display("FAIL max_hold1 c%0d: got g=%b v=%b t=%b expected g=%b t=%b",
                         c, bus1.grants, bus1.grant_valid, bus1.timeout, exp_grants(m1), m1.to);
            end
        end
        tick('0, 1'b0);
    endtask

    task automatic test_random();
        logic [N-1:0] req;
        req = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            tick(req, ($urandom_range(0, 99) == 0));
            checks++;
            if (bus4.grants !== exp_grants(m4) || bus4.grant_valid !== (m4.owner >= 0) ||
                bus4.grant_index !== 2'(m4.index) || bus4.timeout !== m4.to ||
                bus1.grants !== exp_grants(m1) || bus1.grant_valid !== (m1.owner >= 0) ||
                bus1.grant_index !== 2'(m1.index) || bus1.timeout !== m1.to ||
                !$onehot0(bus4.grants) || !$onehot0(bus1.grants)) begin
                errors++;
                $display("FAIL random c%0d req=%b: got g4=%b i=%0d t=%b g1=%b i=%0d t=%b expected g4=%b i=%0d t=%b g1=%b i=%0d t=%b",
                         c, req, bus4.grants, bus4.grant_index, bus4.timeout,
                         bus1.grants, bus1.grant_index, bus1.timeout,
                         exp_grants(m4), m4.index, m4.to, exp_grants(m1), m1.index, m1.to);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus4.requests = '0;
        bus1.requests = '0;
        m4 = model_reset();
        m1 = model_reset();
        test_reset();
        test_rotation();
        test_single_release();
        test_back_to_back();
        test_sole_timeout();
        test_reset_mid_grant();
        test_max_hold1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
